input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage feeding the lights-off game core: takes raw slide switches and the two active-low push buttons from the board pins.
- Synchronises and debounces every input channel.
- Outputs single-cycle button-press pulses and an accumulated switch-toggle mask, consumed through a valid/ack handshake.
- Replaces the game core's ad-hoc change tracking and its fixed-interval sampling.

Parameters:
- N_SW, 10, number of slide-switch channels.
- DEBOUNCE_CYCLES, 500000, cycles an input must hold a new level before it is accepted (10 ms at 50 MHz). Must be >= 2.
- CNT_W, 19, debounce counter width. Must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-high reset
- sw  in  N_SW  raw slide switches, asynchronous to clk
- btn_fix_n  in  1  raw fixed-quiz button, active-low, asynchronous
- btn_rand_n  in  1  raw random-quiz button, active-low, asynchronous
- sw_level  out  N_SW  debounced switch levels
- fix_press  out  1  one-cycle pulse on each debounced press of btn_fix_n
- rand_press  out  1  one-cycle pulse on each debounced press of btn_rand_n
- toggle_mask  out  N_SW  pending toggle parity per switch
- toggle_valid  out  1  high when toggle_mask != 0
- toggle_ack  in  1  consumer takes toggle_mask this cycle

Behaviour:
- Reset (asynchronous assert, all state cleared immediately):
  - sw_level = 0, toggle_mask = 0, toggle_valid = 0, fix_press = 0, rand_press = 0.
  - Internal stable level of each button = 1 (released).
  - Synchroniser flops load the same values as their channel's stable level.
  - All debounce counters = 0.
- Synchroniser: every input passes through two flops before any use.
- Debounce, per channel, independent:
  - If synced != stable, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while synced != stable: stable <= synced and counter <= 0 on that edge.
  - If synced == stable, counter <= 0. Any glitch shorter than DEBOUNCE_CYCLES is rejected.
- Latency: a clean level change reaches sw_level, or produces a press pulse, exactly 2 + DEBOUNCE_CYCLES cycles after the pin changes (synchroniser plus count).
- Buttons:
  - fix_press / rand_press is registered, high for exactly one cycle on the stable 1->0 transition.
  - No pulse is produced on release. No pulse is produced out of reset.
- Toggle accumulator:
  - A stable-level change on switch i sets event[i] for one cycle.
  - Next state: pending <= (toggle_ack ? 0 : pending) ^ event. The ack clears the old contents, but an event arriving in the ack cycle is kept, never lost.
  - Two toggles of the same switch before the ack cancel (XOR parity); this matches the physics of flipping a light twice.
  - toggle_valid is registered and equals |pending.
  - toggle_ack while toggle_valid = 0 is harmless: the next state is just the event vector.
- Several channels settling in the same cycle all update together, with no priority.
- Counters hold at most DEBOUNCE_CYCLES-1 and cannot wrap.
- Reset asserted mid-debounce discards partial counts and pending toggles. The first post-reset accepted change is measured from reset release.

Decomposition:
- Package input_cond_pkg holds:
  - DEBOUNCE_CYCLES_DEFAULT, CNT_W_DEFAULT.
  - BTN_RELEASED = 1'b1.
  - typedef sw_vec_t = logic [N_SW-1:0] with default N_SW = 10.
- Sub-module debounce_ch, one channel containing synchroniser, counter and stable flop.
  - Parameter: reset value.
  - Outputs: stable level and a one-cycle change pulse.
  - Instantiated N_SW + 2 times; the top level holds the edge logic for the buttons and the accumulator.

Test Plan (bench uses DEBOUNCE_CYCLES = 4):
- Reset with sw = 10'h3FF, both buttons held at 0 → all outputs 0 during reset. After release, sw_level = 10'h3FF at cycle 6, toggle_mask = 10'h3FF, toggle_valid = 1. One fix_press pulse and one rand_press pulse occur, since stable levels reset to released.
- sw[3] pulses high for 3 cycles, then low → sw_level and toggle_mask unchanged; no event.
- sw[3] 0→1 held → sw_level[3] = 1 and toggle_mask = 10'h008 at cycle 6. toggle_ack pulse → toggle_mask = 0 and toggle_valid = 0 the next cycle.
- sw[0] toggled twice with stable holds, no ack in between → toggle_mask[0] returns to 0 and toggle_valid drops.
- toggle_ack asserted in the same cycle sw[9]'s event fires, with pending = 10'h001 → next toggle_mask = 10'h200.
- btn_fix_n held low for 100 cycles → exactly one fix_press pulse. Release → no pulse. rst asserted for 1 cycle mid-count → no pulse, counters restart.

Source files
------------

// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared defaults and types for the input conditioner (debounce timing, button idle level, switch vector)
package input_cond_pkg;
  localparam int N_SW_DEFAULT = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT = 19;
  localparam logic BTN_RELEASED = 1'b1;
  typedef logic [N_SW_DEFAULT-1:0] sw_vec_t;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: 2-flop sync + hold counter for one pin; in clk,rst,din_i; out level_o (stable level), change_o (accept pulse, same cycle stable updates)
module debounce_ch
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic change_o
);
  logic s1_q, s2_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    change_o = (s2_q != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    cnt_d = (s2_q == stable_q || change_o) ? '0 : cnt_q + 1'b1;
    stable_d = stable_q ^ change_o;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q <= '0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
  assign level_o = stable_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounced sw_level, fix_press/rand_press pulses, toggle_mask/toggle_valid with toggle_ack from raw sw, btn_fix_n, btn_rand_n
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_SW = N_SW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  input  logic            btn_fix_n,
  input  logic            btn_rand_n,
  output logic [N_SW-1:0] sw_level,
  output logic            fix_press,
  output logic            rand_press,
  output logic [N_SW-1:0] toggle_mask,
  output logic            toggle_valid,
  input  logic            toggle_ack
);
  logic [N_SW-1:0] ev, pending_q, pending_d;
  logic valid_q, fix_q, rand_q, fix_lvl, fix_chg, rand_lvl, rand_chg;
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_VAL(1'b0)) u_sw (
      .clk(clk), .rst(rst), .din_i(sw[i]), .level_o(sw_level[i]), .change_o(ev[i])
    );
  end
  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_VAL(BTN_RELEASED)) u_fix (
    .clk(clk), .rst(rst), .din_i(btn_fix_n), .level_o(fix_lvl), .change_o(fix_chg)
  );
  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_VAL(BTN_RELEASED)) u_rand (
    .clk(clk), .rst(rst), .din_i(btn_rand_n), .level_o(rand_lvl), .change_o(rand_chg)
  );
  always_comb pending_d = (toggle_ack ? '0 : pending_q) ^ ev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      valid_q <= 1'b0;
      fix_q <= 1'b0;
      rand_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q <= |pending_d;
      fix_q <= fix_chg && fix_lvl == BTN_RELEASED;
      rand_q <= rand_chg && rand_lvl == BTN_RELEASED;
    end
  end
  assign toggle_mask = pending_q;
  assign toggle_valid = valid_q;
  assign fix_press = fix_q;
  assign rand_press = rand_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: random and directed stimulus against a sliding-window debounce model
module tb_input_conditioner;
  import input_cond_pkg::*;
  localparam int D = 4;
  localparam logic [11:0] RV = 12'hC00;
  logic clk = 0, rst = 1, btn_fix_n = 1, btn_rand_n = 1, toggle_ack = 0;
  sw_vec_t sw = '0;
  logic [9:0] sw_level, toggle_mask;
  logic fix_press, rand_press, toggle_valid;
  int n_vec = 0, n_bad = 0, fix_cnt = 0, rand_cnt = 0;
  logic [11:0] s1m, s2m, stab;
  logic [11:0] win[$];
  logic [9:0] pend;
  logic vld, fp, rp;
  always #5 clk = ~clk;
  input_conditioner #(.N_SW(10), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_fix_n(btn_fix_n), .btn_rand_n(btn_rand_n),
    .sw_level(sw_level), .fix_press(fix_press), .rand_press(rand_press),
    .toggle_mask(toggle_mask), .toggle_valid(toggle_valid), .toggle_ack(toggle_ack)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    s1m = RV; s2m = RV; stab = RV; win.delete(); pend = '0; vld = 0; fp = 0; rp = 0;
  endtask
  task automatic check_all();
    chk("sw_level", sw_level, stab[9:0]);
    chk("toggle_mask", toggle_mask, pend);
    chk("toggle_valid", toggle_valid, vld);
    chk("fix_press", fix_press, fp);
    chk("rand_press", rand_press, rp);
  endtask
  // A channel accepts when its last D synchronised samples since reset all differ from its stable level.
  task automatic cycle();
    logic [11:0] sy, ev;
    logic all;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      sy = s2m; s2m = s1m; s1m = {btn_rand_n, btn_fix_n, sw};
      win.push_back(sy);
      if (win.size() > D) void'(win.pop_front());
      ev = '0;
      if (win.size() == D)
        for (int c = 0; c < 12; c++) begin
          all = 1;
          foreach (win[j]) if (win[j][c] == stab[c]) all = 0;
          ev[c] = all;
        end
      fp = ev[10] & stab[10];
      rp = ev[11] & stab[11];
      stab = stab ^ ev;
      pend = (toggle_ack ? 10'h0 : pend) ^ ev[9:0];
      vld = |pend;
    end
    #1;
    check_all();
    fix_cnt += int'(fix_press);
    rand_cnt += int'(rand_press);
  endtask
  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask
  task automatic ack();
    toggle_ack = 1; cycle(); toggle_ack = 0;
  endtask
  task automatic pulse_reset(int n);
    rst = 1; model_reset(); #1;
    check_all();
    run(n);
    rst = 0;
  endtask
  initial begin
    sw = 10'h3FF; btn_fix_n = 0; btn_rand_n = 0;
    model_reset();
    run(2);
    rst = 0;
    fix_cnt = 0; rand_cnt = 0;
    run(5);
    chk("init_lvl_early", sw_level, 10'h000);
    cycle();
    chk("init_lvl", sw_level, 10'h3FF);
    chk("init_mask", toggle_mask, 10'h3FF);
    chk("init_valid", toggle_valid, 1'b1);
    run(6);
    chk("init_fix_cnt", fix_cnt, 1);
    chk("init_rand_cnt", rand_cnt, 1);
    btn_fix_n = 1; btn_rand_n = 1; sw = '0;
    run(10);
    ack();
    chk("release_fix_cnt", fix_cnt, 1);
    chk("release_rand_cnt", rand_cnt, 1);
    chk("ack_clear", toggle_mask, 10'h000);
    sw[3] = 1; run(3); sw[3] = 0; run(10);
    chk("glitch_lvl", sw_level, 10'h000);
    chk("glitch_mask", toggle_mask, 10'h000);
    sw[3] = 1; run(6);
    chk("sw3_lvl", sw_level, 10'h008);
    chk("sw3_mask", toggle_mask, 10'h008);
    ack();
    chk("sw3_ack_mask", toggle_mask, 10'h000);
    chk("sw3_ack_valid", toggle_valid, 1'b0);
    sw[0] = 1; run(10);
    chk("sw0_once", toggle_mask, 10'h001);
    sw[0] = 0; run(10);
    chk("sw0_twice", toggle_mask, 10'h000);
    chk("sw0_twice_valid", toggle_valid, 1'b0);
    sw[0] = 1; run(10);
    sw[9] = 1; run(5);
    ack();
    chk("ack_event_same", toggle_mask, 10'h200);
    ack(); run(2);
    fix_cnt = 0;
    btn_fix_n = 0; run(100);
    chk("hold_fix_cnt", fix_cnt, 1);
    btn_fix_n = 1; run(10);
    chk("release_no_pulse", fix_cnt, 1);
    btn_fix_n = 0; run(3);
    pulse_reset(1);
    run(5);
    chk("rst_mid_no_pulse", fix_cnt, 1);
    cycle();
    chk("rst_restart_pulse", fix_cnt, 2);
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 10; b++) if ($urandom_range(0, 15) == 0) sw[b] = ~sw[b];
      if ($urandom_range(0, 15) == 0) btn_fix_n = ~btn_fix_n;
      if ($urandom_range(0, 15) == 0) btn_rand_n = ~btn_rand_n;
      toggle_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) pulse_reset($urandom_range(1, 3));
      else cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
